// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, status codes, register ids, FSM states.
// Also the hazard-term bundle passed from pipe_hazard_detect to pipe_control.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } pstate_e;

  typedef struct packed {
    logic lu;
    logic mp;
    logic rt;
    logic exc_m;
    logic exc_w;
  } hz_t;

  function automatic logic is_exc(logic [2:0] s);
    return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard terms: load/use, mispredict, ret, M/W exceptions.
// In: decode/execute/memory icodes and regs, e_Cnd, m_stat, W_stat. Out: hz_o.
module pipe_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode_i,
  input  logic [3:0] d_srcA_i,
  input  logic [3:0] d_srcB_i,
  input  logic [3:0] E_icode_i,
  input  logic [3:0] E_dstM_i,
  input  logic       e_Cnd_i,
  input  logic [3:0] M_icode_i,
  input  logic [2:0] m_stat_i,
  input  logic [2:0] W_stat_i,
  output hz_t        hz_o
);

  logic e_load;
  logic dst_hit;

  assign e_load  = (E_icode_i == I_MRMOVQ) ||
                   (E_icode_i == I_POPQ);
  // A NONE destination never creates a dependency,
  // even though NONE sources compare equal to it.
  assign dst_hit = (E_dstM_i != REG_NONE) &&
                   ((E_dstM_i == d_srcA_i) ||
                    (E_dstM_i == d_srcB_i));

  assign hz_o.lu    = e_load && dst_hit;
  assign hz_o.mp    = (E_icode_i == I_JXX) && !e_Cnd_i;
  assign hz_o.rt    = (D_icode_i == I_RET) ||
                      (E_icode_i == I_RET) ||
                      (M_icode_i == I_RET);
  assign hz_o.exc_m = is_exc(m_stat_i);
  assign hz_o.exc_w = is_exc(W_stat_i);

endmodule

// File: rtl/pipe_control.sv
// Y86-64 pipeline hazard controller: stall/bubble, exception drain FSM, CC gate.
// Perf counters lu_cnt/mp_cnt/ret_cnt exist only with PIPE_PERF_CNT_EN.
module pipe_control
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       cpu_stat,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  hz_t     hz;
  pstate_e state_q, state_d;
  logic [2:0] cpu_stat_q, cpu_stat_d;

  pipe_hazard_detect u_hz (
    .D_icode_i (D_icode),
    .d_srcA_i  (d_srcA),
    .d_srcB_i  (d_srcB),
    .E_icode_i (E_icode),
    .E_dstM_i  (E_dstM),
    .e_Cnd_i   (e_Cnd),
    .M_icode_i (M_icode),
    .m_stat_i  (m_stat),
    .W_stat_i  (W_stat),
    .hz_o      (hz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cpu_stat_q <= S_AOK;
    end else begin
      state_q    <= state_d;
      cpu_stat_q <= cpu_stat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (hz.exc_w)      state_d = ST_HALT;
        else if (hz.exc_m) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (hz.exc_w) state_d = ST_HALT;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
    cpu_stat_d = cpu_stat_q;
    if (state_q != ST_HALT && state_d == ST_HALT)
      cpu_stat_d = W_stat;
  end

  always_comb begin
    F_stall  = hz.lu | hz.rt;
    D_stall  = hz.lu;
    D_bubble = hz.mp | (hz.rt & ~hz.lu);
    E_bubble = hz.mp | hz.lu;
    M_bubble = hz.exc_m | hz.exc_w;
    W_stall  = hz.exc_w;
    set_cc   = (E_icode == I_OPQ) &
               ~hz.exc_m & ~hz.exc_w;
    // Reset overrides state: the async clear of
    // state_q may lag rst_n by a delta.
    priority case (1'b1)
      !rst_n: begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
      end
      (state_q == ST_HALT): begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
        set_cc   = 1'b0;
      end
      (state_q == ST_DRAIN): set_cc = 1'b0;
      default: ;
    endcase
  end

  assign halted   = (state_q == ST_HALT);
  assign cpu_stat = cpu_stat_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             cnt_en;

  function automatic logic [CNT_W-1:0] sat_inc(
    logic [CNT_W-1:0] c
  );
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign cnt_en = (state_q != ST_HALT);

  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    mp_cnt_d  = mp_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (cnt_en) begin
      if (hz.lu) lu_cnt_d = sat_inc(lu_cnt_q);
      if (hz.mp) mp_cnt_d = sat_inc(mp_cnt_q);
      if (hz.rt && !hz.lu)
        ret_cnt_d = sat_inc(ret_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q  <= '0;
      mp_cnt_q  <= '0;
      ret_cnt_q <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mp_cnt_q  <= mp_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign lu_cnt  = lu_cnt_q;
  assign mp_cnt  = mp_cnt_q;
  assign ret_cnt = ret_cnt_q;
`else
  assign lu_cnt  = '0;
  assign mp_cnt  = '0;
  assign ret_cnt = '0;
`endif

endmodule
